uvmt_cv32e40s_achk_checker: RTL

//  Bench-side checker for the OBI address-phase integrity signals the core drives (achk, reqpar).
//  One instance each taps obi_instr_if and obi_data_if; it is the counterpart of the rchk generator.

---
 rtl/uvmt_cv32e40s_achk_checker.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/uvmt_cv32e40s_achk_checker.sv
// uvmt_cv32e40s_achk_checker
//   Bench-side checker for the OBI address-phase integrity signals driven by the core.
//   It recomputes achk and reqpar, checks that the request phase holds stable while it waits
//   for a grant, and tracks how many granted transactions still await a response.
//   Errors are reported as registered one-cycle pulses, a sticky flag and a saturating counter.
//
//   Optional feature: define UVMT_CV32E40S_ACHK_CHECKER_ASSERT_EN to embed assertions that
//   raise $error on every error pulse. Without the macro only the outputs report errors.
//
// Ports
//   clk, rst_n          bench clock, asynchronous active-low reset
//   req_i, reqpar_i     OBI request and its odd-parity companion
//   gnt_i, rvalid_i     OBI grant and response valid
//   addr_i, prot_i, memtype_i, dbg_i, we_i, be_i, wdata_i   address-phase payload
//   achk_i              address-phase checksum from the core
//   achk_err_o          pulse: achk mismatch, achk_err_bits_o gives the failing bits
//   reqpar_err_o        pulse: reqpar_i != ~req_i
//   protocol_err_o      pulse: stability or outstanding-count violation
//   err_sticky_o        set by any error pulse, cleared only by reset
//   err_cnt_o           saturating count of cycles carrying at least one error pulse
//   outstanding_o       current count of granted-but-unanswered transactions
module uvmt_cv32e40s_achk_checker #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter bit          IS_DATA         = 1'b1,
  parameter int unsigned ERR_CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_i,
  input  logic                 reqpar_i,
  input  logic                 gnt_i,
  input  logic [31:0]          addr_i,
  input  logic [2:0]           prot_i,
  input  logic [1:0]           memtype_i,
  input  logic                 dbg_i,
  input  logic                 we_i,
  input  logic [3:0]           be_i,
  input  logic [31:0]          wdata_i,
  input  logic [11:0]          achk_i,
  input  logic                 rvalid_i,
  output logic                 achk_err_o,
  output logic [11:0]          achk_err_bits_o,
  output logic                 reqpar_err_o,
  output logic                 protocol_err_o,
  output logic                 err_sticky_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  output logic [2:0]           outstanding_o
);

  localparam int unsigned SnapW  = 87;
  localparam logic [2:0]  MaxOut = 3'(MAX_OUTSTANDING);

  typedef enum logic [0:0] {StIdle, StWaitGnt} state_e;

  state_e state_q, state_d;

  // Instruction ports carry no write payload; those groups are treated as all-zero.
  logic        we_m;
  logic [3:0]  be_m;
  logic [31:0] wdata_m;
  assign we_m    = IS_DATA ? we_i    : 1'b0;
  assign be_m    = IS_DATA ? be_i    : 4'h0;
  assign wdata_m = IS_DATA ? wdata_i : 32'h0;

  logic [11:0] achk_exp;
  always_comb begin
    achk_exp[0]  = ~^addr_i[7:0];
    achk_exp[1]  = ~^addr_i[15:8];
    achk_exp[2]  = ~^addr_i[23:16];
    achk_exp[3]  = ~^addr_i[31:24];
    achk_exp[4]  = ~^{prot_i, memtype_i};
    achk_exp[5]  = ~^{be_m, we_m};
    achk_exp[6]  = ~^dbg_i;
    achk_exp[7]  = 1'b1; // no atop field on this interface
    achk_exp[8]  = ~^wdata_m[7:0];
    achk_exp[9]  = ~^wdata_m[15:8];
    achk_exp[10] = ~^wdata_m[23:16];
    achk_exp[11] = ~^wdata_m[31:24];
  end

  logic [11:0] achk_diff;
  logic        achk_err_d, reqpar_err_d;
  assign achk_diff    = req_i ? (achk_exp ^ achk_i) : 12'h000;
  assign achk_err_d   = |achk_diff;
  assign reqpar_err_d = (reqpar_i == req_i);

  // Request-phase snapshot taken when a request first stalls for a grant.
  logic [SnapW-1:0] snap_q, snap_now;
  logic             snap_load, stab_err;
  assign snap_now = {addr_i, prot_i, memtype_i, dbg_i, we_m, be_m, wdata_m, achk_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_i && !gnt_i) state_d = StWaitGnt;
      end
      StWaitGnt: begin
        if (!req_i || (snap_now != snap_q) || gnt_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    snap_load = 1'b0;
    stab_err  = 1'b0;
    unique case (state_q)
      StIdle:    snap_load = req_i && !gnt_i;
      StWaitGnt: stab_err  = !req_i || (snap_now != snap_q);
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q <= '0;
    end else if (snap_load) begin
      snap_q <= snap_now;
    end
  end

  // Outstanding tracking: a grant and a response in the same cycle cancel out.
  logic       hs, out_err;
  logic [2:0] out_d;
  assign hs = req_i && gnt_i;

  always_comb begin
    out_d   = outstanding_o;
    out_err = 1'b0;
    if (hs && !rvalid_i) begin
      if (outstanding_o >= MaxOut) out_err = 1'b1;
      else                         out_d   = outstanding_o + 3'd1;
    end else if (rvalid_i && !hs) begin
      if (outstanding_o == 3'd0) out_err = 1'b1;
      else                       out_d   = outstanding_o - 3'd1;
    end
  end

  logic proto_err_d, any_err_d;
  assign proto_err_d = stab_err || out_err;
  assign any_err_d   = achk_err_d || reqpar_err_d || proto_err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      achk_err_o      <= 1'b0;
      achk_err_bits_o <= 12'h000;
      reqpar_err_o    <= 1'b0;
      protocol_err_o  <= 1'b0;
      err_sticky_o    <= 1'b0;
      err_cnt_o       <= '0;
      outstanding_o   <= 3'd0;
    end else begin
      achk_err_o      <= achk_err_d;
      achk_err_bits_o <= achk_diff;
      reqpar_err_o    <= reqpar_err_d;
      protocol_err_o  <= proto_err_d;
      err_sticky_o    <= err_sticky_o || any_err_d;
      outstanding_o   <= out_d;
      if (any_err_d && (err_cnt_o != {ERR_CNT_W{1'b1}})) begin
        err_cnt_o <= err_cnt_o + 1'b1;
      end
    end
  end

`ifdef UVMT_CV32E40S_ACHK_CHECKER_ASSERT_EN
  localparam string PortName = IS_DATA ? "obi_data_if" : "obi_instr_if";

  a_achk: assert property (@(posedge clk) disable iff (!rst_n) !achk_err_o)
    else $error("%s: achk error addr=%h bits=%h", PortName, addr_i, achk_err_bits_o);
  a_reqpar: assert property (@(posedge clk) disable iff (!rst_n) !reqpar_err_o)
    else $error("%s: reqpar error addr=%h bits=%h", PortName, addr_i, achk_err_bits_o);
  a_proto: assert property (@(posedge clk) disable iff (!rst_n) !protocol_err_o)
    else $error("%s: protocol error addr=%h bits=%h", PortName, addr_i, achk_err_bits_o);
`endif

endmodule
